// File: rtl/tmds_decode_channel.sv
// TMDS receive channel: 10b symbol decode plus bitslip-driven word alignment on control-token runs.
// Optional macro TMDS_DECODE_LOCKLOSS_CNT_EN adds the saturating pLockLossCnt output.
module tmds_decode_channel #(
    parameter int kCtlTokenThresh = 128,
    parameter int kTimeout        = 4096,
    parameter int kSettleCycles   = 3
) (
    input  logic       PixelClk,
    input  logic       aRst_n,
    input  logic [9:0] pDataIn,
    output logic       pBitslip,
    output logic       pAligned,
    output logic [7:0] pDataOut,
    output logic       pC0,
    output logic       pC1,
    output logic       pVDE,
    output logic [3:0] pSlipCount
`ifdef TMDS_DECODE_LOCKLOSS_CNT_EN
    ,
    output logic [7:0] pLockLossCnt
`endif
);

    localparam int kTimerW  = $clog2(kTimeout + 1);
    localparam int kRunW    = $clog2(kCtlTokenThresh + 1);
    localparam int kSettleW = (kSettleCycles > 1) ? $clog2(kSettleCycles) : 1;

    localparam logic [kTimerW-1:0]  kTimerLast  = kTimerW'(kTimeout - 1);
    localparam logic [kTimerW-1:0]  kTimerMax   = kTimerW'(kTimeout);
    localparam logic [kRunW-1:0]    kRunLast    = kRunW'(kCtlTokenThresh - 1);
    localparam logic [kSettleW-1:0] kSettleLoad = kSettleW'((kSettleCycles > 0) ? kSettleCycles - 1 : 0);

    // state     | meaning
    // ST_SEARCH | counting consecutive control tokens, timer running toward a slip
    // ST_SLIP   | one-cycle bitslip request to the deserializer
    // ST_SETTLE | deserializer realigning, run and timer held at zero
    // ST_LOCKED | word-aligned, timer watches for control-token starvation
    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    state_t               state_q;
    logic [kTimerW-1:0]   timer_q;
    logic [kRunW-1:0]     run_q;
    logic [kSettleW-1:0]  settle_q;
    logic [3:0]           slip_cnt_q;
    logic                 bitslip_q;
    logic                 aligned_q;

    logic                 s1_ctl_d,  s1_ctl_q;
    logic [1:0]           s1_c_d,    s1_c_q;
    logic [7:0]           s1_data_d, s1_data_q;
    logic [7:0]           inv_bits;

    logic [7:0]           data_q;
    logic                 vde_q;
    logic [1:0]           c_q;

    logic                 run_hit;
    logic                 search_to;
    logic                 locked_to;
    logic                 aligned_d;
    logic [kTimerW-1:0]   timer_inc;

    always_comb begin
        s1_ctl_d  = 1'b1;
        s1_c_d    = 2'b00;
        s1_data_d = '0;
        case (pDataIn)
            10'h354: s1_c_d = 2'b00;
            10'h0AB: s1_c_d = 2'b01;
            10'h154: s1_c_d = 2'b10;
            10'h2AB: s1_c_d = 2'b11;
            default: s1_ctl_d = 1'b0;
        endcase
        inv_bits     = pDataIn[9] ? ~pDataIn[7:0] : pDataIn[7:0];
        s1_data_d[0] = inv_bits[0];
        for (int i = 1; i < 8; i++) begin
            s1_data_d[i] = pDataIn[8] ? (inv_bits[i] ^ inv_bits[i-1])
                                      : ~(inv_bits[i] ^ inv_bits[i-1]);
        end
    end

    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            s1_ctl_q  <= 1'b0;
            s1_c_q    <= 2'b00;
            s1_data_q <= '0;
        end else begin
            s1_ctl_q  <= s1_ctl_d;
            s1_c_q    <= s1_c_d;
            s1_data_q <= s1_data_d;
        end
    end

    assign run_hit   = s1_ctl_q && (run_q == kRunLast);
    assign search_to = (timer_q >= kTimerLast);
    assign locked_to = !s1_ctl_q && (timer_q >= kTimerLast);
    assign timer_inc = (timer_q == kTimerMax) ? timer_q : timer_q + 1'b1;

    // Output stage gates on the next alignment so pVDE never outlives pAligned.
    always_comb begin
        aligned_d = 1'b0;
        case (state_q)
            ST_SEARCH: aligned_d = run_hit;
            ST_LOCKED: aligned_d = !locked_to;
            default:   aligned_d = 1'b0;
        endcase
    end

`ifdef TMDS_DECODE_LOCKLOSS_CNT_EN
    logic [7:0] loss_cnt_q;
`endif

    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            state_q    <= ST_SEARCH;
            timer_q    <= '0;
            run_q      <= '0;
            settle_q   <= '0;
            slip_cnt_q <= 4'd0;
            bitslip_q  <= 1'b0;
            aligned_q  <= 1'b0;
`ifdef TMDS_DECODE_LOCKLOSS_CNT_EN
            loss_cnt_q <= 8'd0;
`endif
        end else begin
            bitslip_q <= 1'b0;
            aligned_q <= aligned_d;
            case (state_q)
                ST_SEARCH: begin
                    if (run_hit) begin
                        state_q    <= ST_LOCKED;
                        timer_q    <= '0;
                        run_q      <= '0;
                        slip_cnt_q <= 4'd0;
                    end else if (search_to) begin
                        state_q    <= ST_SLIP;
                        bitslip_q  <= 1'b1;
                        timer_q    <= '0;
                        run_q      <= '0;
                        slip_cnt_q <= (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
                    end else begin
                        timer_q <= timer_inc;
                        run_q   <= s1_ctl_q ? run_q + 1'b1 : '0;
                    end
                end
                ST_SLIP: begin
                    state_q  <= ST_SETTLE;
                    settle_q <= kSettleLoad;
                    timer_q  <= '0;
                    run_q    <= '0;
                end
                ST_SETTLE: begin
                    timer_q <= '0;
                    run_q   <= '0;
                    if (settle_q == '0) begin
                        state_q <= ST_SEARCH;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (s1_ctl_q) begin
                        timer_q <= '0;
                    end else if (locked_to) begin
                        state_q <= ST_SEARCH;
                        timer_q <= '0;
                        run_q   <= '0;
`ifdef TMDS_DECODE_LOCKLOSS_CNT_EN
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_q <= loss_cnt_q + 8'd1;
                        end
`endif
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                default: begin
                    state_q <= ST_SEARCH;
                    timer_q <= '0;
                    run_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            data_q <= '0;
            vde_q  <= 1'b0;
            c_q    <= 2'b00;
        end else begin
            if (s1_ctl_q) begin
                c_q <= s1_c_q;
            end
            if (aligned_d && !s1_ctl_q) begin
                vde_q  <= 1'b1;
                data_q <= s1_data_q;
            end else begin
                vde_q  <= 1'b0;
                data_q <= '0;
            end
        end
    end

    assign pBitslip   = bitslip_q;
    assign pAligned   = aligned_q;
    assign pDataOut   = data_q;
    assign pC0        = c_q[0];
    assign pC1        = c_q[1];
    assign pVDE       = vde_q;
    assign pSlipCount = slip_cnt_q;
`ifdef TMDS_DECODE_LOCKLOSS_CNT_EN
    assign pLockLossCnt = loss_cnt_q;
`endif

endmodule

// File: doc/tmds_decode_channel.md
Name: tmds_decode_channel

Overview:
- Receive-side counterpart of the DVI transmit path: decodes one TMDS channel from 10-bit symbols back into 8-bit pixel data, control bits C0/C1 and data-enable.
- Sits after a 1:10 deserializer (ISERDES-style) in the PixelClk domain.
- Drives word alignment by pulsing bitslip until control tokens lock.
- Three instances plus channel deskew form a dvi2rgb-style receiver whose outputs mirror the vid_p* interface.

Parameters:
- kCtlTokenThresh, 128: consecutive control tokens required to declare lock.
- kTimeout, 4096: cycles without lock (SEARCH) or without any control token (LOCKED) before acting.
- kSettleCycles, 3: cycles ignored after a bitslip pulse while the deserializer realigns.

Ports:
- PixelClk  in  1  pixel clock; all logic on rising edge.
- aRst_n  in  1  asynchronous, active-low reset.
- pDataIn  in  10  deserialized TMDS symbol; bit 0 is first on the wire; valid every cycle.
- pBitslip  out  1  one-cycle pulse requesting a 1-bit word rotation from the deserializer.
- pAligned  out  1  channel word-locked.
- pDataOut  out  8  decoded pixel byte.
- pC0  out  1  control bit 0.
- pC1  out  1  control bit 1.
- pVDE  out  1  video data enable.
- pSlipCount  out  4  bitslips issued since last lock, 0..9, wraps 9->0.

Behaviour:
- Reset (aRst_n=0, asynchronous): all outputs 0, FSM in SEARCH, all counters 0. Reset mid-operation drops lock immediately.
- Decode stage 1 (registered):
  - Classify symbol. Control tokens: 0x354 gives C=00, 0x0AB gives 01, 0x154 gives 10, 0x2AB gives 11; C is {pC1,pC0}.
  - Any other symbol is data: if bit9=1, q = ~bits[7:0], else q = bits[7:0].
  - d0 = q0. For i=1..7: if bit8=1, di = qi ^ q(i-1); else di = ~(qi ^ q(i-1)).
- Output stage 2 (registered): total latency 2 cycles, pDataIn to pDataOut/pC*/pVDE.
  - Data symbol: pVDE=1, pDataOut=d, pC0/pC1 hold their last control values.
  - Control token: pVDE=0, pDataOut=0, pC0/pC1 update.
  - pAligned=0: pVDE forced 0 and pDataOut=0; pC0/pC1 still decode.
- FSM states:
  - SEARCH:
    - runCnt increments per control token and clears on any data symbol.
    - runCnt reaching kCtlTokenThresh goes to LOCKED; pAligned=1 on the next edge; pSlipCount cleared.
    - timer reaching kTimeout without lock goes to SLIP.
  - SLIP: pBitslip=1 for exactly one cycle; pSlipCount increments (9 wraps to 0); go to SETTLE.
  - SETTLE: wait kSettleCycles cycles with runCnt and timer held at 0, then return to SEARCH.
  - LOCKED:
    - timer clears on every control token.
    - timer reaching kTimeout goes to SEARCH, pAligned=0 the next cycle, runCnt 0.
    - Data bursts of any length below kTimeout do not break lock.
- Timer width: ceil(log2(kTimeout+1)); it saturates and never wraps.
- Same cycle that completes a run and hits timeout in SEARCH: lock wins.
- pBitslip is never asserted outside SLIP; it is never asserted on consecutive cycles.

Optional Feature:
- Macro TMDS_DECODE_LOCKLOSS_CNT_EN.
- Defined: adds output port pLockLossCnt (8 bits), reset 0. It increments by 1 on every LOCKED->SEARCH transition and saturates at 255. Reset is the only clear.
- Undefined: no port and no counter. All other behaviour is identical.

Test Plan:
- Reset values: hold aRst_n=0 with random pDataIn -> all outputs 0. Release, drive 4096 cycles of 0x100 -> pBitslip pulses once at cycle 4096 of SEARCH, pSlipCount=1.
- Lock: 128 consecutive 0x354 -> pAligned=1 on the edge after the 128th sample, pBitslip never asserted. 127 tokens, one 0x100, then 127 tokens -> no lock.
- Data decode after lock: 0x100 -> pDataOut=0x00 with pVDE=1 two cycles later. 0x2FF -> 0xFE. Then 0x0AB -> pVDE=0, pC0=1, pC1=0, pDataOut=0x00.
- Alignment: bench deserializer model feeds the token stream rotated by 3 bits and rotates one bit per pBitslip -> lock after correct slips, pSlipCount cleared to 0. Also check pSlipCount wraps 9->0 on an unlockable stream.
- Lock loss: after lock, 4096 cycles of data symbols only -> pAligned=0 and pVDE forced 0. With TMDS_DECODE_LOCKLOSS_CNT_EN, pLockLossCnt=1.
- Async reset asserted mid-LOCKED between clock edges -> pAligned and pVDE drop to 0 immediately, not at the next clock edge.
